// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle between the hazard sequencer and the 5-stage core.
// The master side (pipeline) presents the hazard sources; the slave side
// (pipe_hazard_ctrl) returns buffer enables, flushes and mul/div handshake.
interface pipe_hazard_ctrl_if;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_RegRD;
  logic [3:0] IFID_RegRS;
  logic [3:0] IFID_RegRT;
  logic       IFID_UseRS;
  logic       IFID_UseRT;
  logic       IDEX_MulDiv;
  logic       IDEX_IsDiv;
  logic       Branch_Taken;
  logic       Mem_Wait;
  logic       PC_Write;
  logic       IFID_Write;
  logic       IDEX_Write;
  logic       EXM_Write;
  logic       FLUSH_IF;
  logic       FLUSH_ID;
  logic       FLUSH_EX;
  logic       MD_Start;
  logic       MD_Busy;

  modport master (
    output IDEX_MemRead, IDEX_RegRD, IFID_RegRS, IFID_RegRT, IFID_UseRS,
           IFID_UseRT, IDEX_MulDiv, IDEX_IsDiv, Branch_Taken, Mem_Wait,
    input  PC_Write, IFID_Write, IDEX_Write, EXM_Write, FLUSH_IF, FLUSH_ID,
           FLUSH_EX, MD_Start, MD_Busy
  );

  modport slave (
    input  IDEX_MemRead, IDEX_RegRD, IFID_RegRS, IFID_RegRT, IFID_UseRS,
           IFID_UseRT, IDEX_MulDiv, IDEX_IsDiv, Branch_Taken, Mem_Wait,
    output PC_Write, IFID_Write, IDEX_Write, EXM_Write, FLUSH_IF, FLUSH_ID,
           FLUSH_EX, MD_Start, MD_Busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 16-bit 5-stage core.
// Handles memory-wait freeze, taken-branch squash, multi-cycle mul/div hold
// and load-use stall, in that priority order. Outputs are combinational from
// state and inputs so a hazard is answered in the cycle it appears.
// Optional build macro PIPE_STALL_CNT_EN adds a saturating 16-bit counter of
// cycles in which the PC was held (Stall_Cnt).
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 17,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0] Stall_Cnt,
`endif
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_LAST} state_t;

  // The entry cycle is one of the EX-occupancy cycles and MD_LAST is another,
  // so the down-counter covers the remaining LAT-2 cycles.
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ld_val;
  logic             load_use;

  logic pc_w, ifid_w, idex_w, exm_w;
  logic f_if, f_id, f_ex;
  logic md_start, md_busy;

  assign load_use = bus.IDEX_MemRead &
                    ((bus.IFID_UseRS & (bus.IFID_RegRS == bus.IDEX_RegRD)) |
                     (bus.IFID_UseRT & (bus.IFID_RegRT == bus.IDEX_RegRD)));

  assign ld_val = bus.IDEX_IsDiv ? DIV_LD : MUL_LD;

  // State register and latency counter; reset aborts any mul/div in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode with fixed hazard priority.
  always_comb begin
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    idex_w   = 1'b1;
    exm_w    = 1'b1;
    f_if     = 1'b0;
    f_id     = 1'b0;
    f_ex     = 1'b0;
    md_start = 1'b0;
    md_busy  = (state_q != RUN);
    state_d  = state_q;
    cnt_d    = cnt_q;

    if (rst) begin
      // Present the reset output pattern while reset is held, regardless of
      // any operation being aborted.
      md_busy = 1'b0;
    end else if (bus.Mem_Wait) begin
      // Freeze every buffer; state and counter hold, busy stays as-is.
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
      exm_w  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.Branch_Taken) begin
            // Squash the two wrong-path instructions; the target loads.
            f_if = 1'b1;
            f_id = 1'b1;
          end else if (bus.IDEX_MulDiv) begin
            md_start = 1'b1;
            md_busy  = 1'b1;
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            f_ex     = 1'b1;
            cnt_d    = ld_val;
            state_d  = (ld_val == '0) ? MD_LAST : MD_BUSY;
          end else if (load_use) begin
            // One bubble is enough: next cycle the load has left EX.
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            f_id   = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_w = 1'b0;
          f_ex   = 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = MD_LAST;
          end
        end
        MD_LAST: begin
          // Result is captured into EX/MEM at this edge.
          cnt_d   = '0;
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.PC_Write   = pc_w;
  assign bus.IFID_Write = ifid_w;
  assign bus.IDEX_Write = idex_w;
  assign bus.EXM_Write  = exm_w;
  assign bus.FLUSH_IF   = f_if;
  assign bus.FLUSH_ID   = f_id;
  assign bus.FLUSH_EX   = f_ex;
  assign bus.MD_Start   = md_start;
  assign bus.MD_Busy    = md_busy;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_d = stall_q;
    if (!pc_w && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign Stall_Cnt = stall_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 16-bit 5-stage core.
- Drives write-enables and flushes for the PC, IF/ID, ID/EX and EX/MEM buffers.
- Detects load-use hazards and squashes wrong-path instructions on a taken branch resolved in stage 3.
- Holds the pipe while the multi-cycle multiply/divide unit produces ALU_Result/ALU_Remainder, and freezes everything on a memory wait.

Parameters:
- MUL_LAT, 4: total EX-occupancy cycles for a multiply; legal range 2..2^CNT_W.
- DIV_LAT, 17: total EX-occupancy cycles for a divide; legal range 2..2^CNT_W.
- CNT_W, 5: width of the latency down-counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RegRD  in  4  destination register of the instruction in EX.
- IFID_RegRS  in  4  source A of the instruction in ID.
- IFID_RegRT  in  4  source B of the instruction in ID.
- IFID_UseRS  in  1  ID instruction reads RS.
- IFID_UseRT  in  1  ID instruction reads RT.
- IDEX_MulDiv  in  1  instruction in EX is a multiply or divide.
- IDEX_IsDiv  in  1  qualifies IDEX_MulDiv: 1 = divide, 0 = multiply.
- Branch_Taken  in  1  branch in EX resolved taken.
- Mem_Wait  in  1  data memory not ready.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID buffer enable.
- IDEX_Write  out  1  ID/EX buffer enable.
- EXM_Write  out  1  EX/MEM buffer enable.
- FLUSH_IF  out  1  clear IF/ID.
- FLUSH_ID  out  1  zero ID/EX controls (insert bubble).
- FLUSH_EX  out  1  zero EX/MEM contents.
- MD_Start  out  1  one-cycle start pulse to the mul/div unit.
- MD_Busy  out  1  mul/div unit occupied.

Behaviour:
- Clocking and reset:
  - Single clock; rst is synchronous and active-high.
  - Reset state is RUN with cnt=0.
  - Reset outputs: all *_Write=1, all FLUSH_*=0, MD_Start=0, MD_Busy=0.
  - Reset asserted mid-multiply/divide aborts the operation: RUN next cycle, cnt=0, no MD_Start.
- Registered state: FSM {RUN, MD_BUSY, MD_LAST} and cnt[CNT_W-1:0]. All outputs are combinational from state and inputs, so a hazard is answered in the same cycle.
- Priority in every state, high to low: Mem_Wait > Branch_Taken > mul/div > load-use.
- Mem_Wait=1:
  - All *_Write=0, all FLUSH_*=0, MD_Start=0.
  - State and cnt frozen; MD_Busy keeps its state-derived value.
- RUN, Branch_Taken=1:
  - FLUSH_IF=1, FLUSH_ID=1, PC_Write=1 (target loads), other writes =1.
  - IDEX_MulDiv is ignored that cycle.
  - Any load-use hazard is ignored, since the ID instruction is squashed.
- RUN, IDEX_MulDiv=1:
  - MD_Start=1, MD_Busy=1.
  - PC_Write, IFID_Write, IDEX_Write = 0; FLUSH_EX=1; EXM_Write=1 so the bubble is captured.
  - cnt <= (IDEX_IsDiv ? DIV_LAT : MUL_LAT) - 2.
  - Next state: MD_LAST if the loaded value is 0, else MD_BUSY.
- MD_BUSY:
  - Same stall/flush outputs as the entry cycle, except MD_Start=0.
  - cnt decrements each cycle; when cnt==1, next state is MD_LAST.
  - Branch_Taken and load-use are not evaluated.
- MD_LAST:
  - MD_Busy=1, FLUSH_EX=0, all *_Write=1, so the result enters EX/MEM at this edge.
  - Next state RUN.
  - Total EX occupancy is exactly MUL_LAT or DIV_LAT cycles.
- Load-use (RUN only, no higher-priority event):
  - Hazard condition: IDEX_MemRead & ((IFID_UseRS & IFID_RegRS==IDEX_RegRD) | (IFID_UseRT & IFID_RegRT==IDEX_RegRD)).
  - All 16 register numbers compare, including R0 and R15.
  - Response: PC_Write=0, IFID_Write=0, FLUSH_ID=1 for exactly one cycle.
  - The following cycle re-evaluates normally; the load has moved on, so there is no second stall.
- No event: all *_Write=1, all FLUSH_*=0.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined:
  - Adds output Stall_Cnt[15:0], which increments each cycle PC_Write=0.
  - The count saturates at 16'hFFFF, resets to 0 on rst, and does not wrap.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> all *_Write=1, FLUSH_*=0, MD_Busy=0 on the first cycle after release.
- Load-use: IDEX_MemRead=1, IDEX_RegRD=3, IFID_RegRT=3, IFID_UseRT=1 -> PC_Write=0, IFID_Write=0, FLUSH_ID=1 for exactly one cycle; with IFID_UseRT=0 -> no stall.
- Divide: IDEX_MulDiv=1, IDEX_IsDiv=1 at cycle t -> MD_Start only at t; FLUSH_EX=1 during t..t+15; MD_LAST at t+16 with EXM_Write=1, FLUSH_EX=0; RUN at t+17. Multiply gives MD_LAST at t+3.
- Branch vs mul/div vs load-use: Branch_Taken=1, IDEX_MulDiv=1 and a load-use match in the same cycle -> FLUSH_IF=FLUSH_ID=1, PC_Write=1, MD_Start=0.
- Mem_Wait mid-divide: assert for 3 cycles at cnt=7 -> all writes 0, cnt holds 7; after release, completion is delayed by exactly 3 cycles.
- Reset mid-multiply: rst at the second busy cycle -> RUN next cycle, MD_Busy=0. With PIPE_STALL_CNT_EN defined, Stall_Cnt returns to 0.
